// File: rtl/mem_req_pkg.sv
// Shared types for the memory requester: default widths, control FSM states
// and the store-buffer entry layout.
package mem_req_pkg;
  localparam int MEM_DATA_W = 20;
  localparam int MEM_ADDR_W = 5;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} req_state_t;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
  } sb_entry_t;
endpackage

// File: rtl/mem_store_buf.sv
// Circular store buffer: push at tail, pop at head, plus a youngest-first
// address search used for store-to-load forwarding.
module mem_store_buf
  import mem_req_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          push,
  input  sb_entry_t                     push_ent,
  input  logic                          pop,
  output sb_entry_t                     head_ent,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          empty,
  output logic                          full,
  input  logic [MEM_ADDR_W-1:0]         match_addr,
  output logic                          match_hit,
  output logic [MEM_DATA_W-1:0]         match_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t        ents [DEPTH];
  logic [PTR_W-1:0] head, tail;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign head_ent = ents[head];

  // DEPTH is a power of two, so pointers wrap by plain truncation.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        ents[tail] <= push_ent;
        tail       <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Scan oldest to youngest; the last hit wins, giving youngest-match data.
  always_comb begin
    match_hit  = 1'b0;
    match_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count && ents[head + PTR_W'(i)].addr == match_addr) begin
        match_hit  = 1'b1;
        match_data = ents[head + PTR_W'(i)].data;
      end
    end
  end
endmodule

// File: rtl/mem_requester.sv
// Memory initiator: PC/fetch on the instruction port, loads and buffered stores
// on the data port. Define MEM_REQ_FWD_EN for store-to-load forwarding.
module mem_requester
  import mem_req_pkg::*;
#(
  parameter int DATA_W   = MEM_DATA_W,
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int SB_DEPTH = 2,
  parameter int RESET_PC = 0
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              f_stall,
  input  logic              f_redirect,
  input  logic [ADDR_W-1:0] f_target,
  output logic [ADDR_W-1:0] f_pc,
  output logic [DATA_W-1:0] f_instr,
  output logic              f_valid,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  input  logic              sb_flush,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              sb_empty,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] q,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] data,
  output logic              wr_en,
  input  logic [DATA_W-1:0] q_mem
);
  localparam int CNT_W = $clog2(SB_DEPTH) + 1;

  req_state_t        state;
  sb_entry_t         head_ent, push_ent;
  logic [CNT_W-1:0]  count;
  logic              full, ld_rdy, ld_acc, st_acc, fwd_hit, drain;
  logic [DATA_W-1:0] fwd_data;

  mem_store_buf #(.DEPTH(SB_DEPTH)) u_sb (
    .clk        (Clock),
    .rstn       (Resetn),
    .push       (st_acc),
    .push_ent   (push_ent),
    .pop        (drain),
    .head_ent   (head_ent),
    .count      (count),
    .empty      (sb_empty),
    .full       (full),
    .match_addr (req_addr),
    .match_hit  (fwd_hit),
    .match_data (fwd_data)
  );

  // Without forwarding a load only issues into an empty buffer, so the match
  // search can never hit and loads always read memory.
`ifdef MEM_REQ_FWD_EN
  assign ld_rdy = !full;
`else
  assign ld_rdy = !full && sb_empty;
`endif

  assign req_ready = (state == RUN) && (req_we || ld_rdy);
  assign ld_acc    = req_valid && !req_we && req_ready;
  assign st_acc    = req_valid && req_we && req_ready;
  assign drain     = !sb_empty && !(ld_acc && !fwd_hit);
  assign wr_en     = drain && Resetn;
  assign mem_addr  = (ld_acc && !fwd_hit) ? req_addr : head_ent.addr;
  assign data      = head_ent.data;
  assign addr      = f_pc;
  assign push_ent  = {req_addr, req_wdata};

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      f_pc    <= ADDR_W'(RESET_PC);
      f_instr <= '0;
      f_valid <= 1'b0;
    end else if (f_redirect || !f_stall) begin
      f_pc    <= f_redirect ? f_target : f_pc + 1'b1;
      f_instr <= q;
      f_valid <= !f_redirect;
    end
  end

  // FLUSH leaves on the edge that pops the final entry (count <= 1 there).
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state     <= RUN;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= ld_acc;
      if (ld_acc) rsp_data <= fwd_hit ? fwd_data : q_mem;
      if (state == RUN) begin
        if (sb_flush && !sb_empty) state <= FLUSH;
      end else if (count <= CNT_W'(1)) begin
        state <= RUN;
      end
    end
  end
endmodule

// File: tb/tb_mem_requester.sv
// Bench for mem_requester: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_requester;
  localparam int DW = 20;
  localparam int AW = 5;
  localparam int DEPTH = 2;
`ifdef MEM_REQ_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn, f_stall, f_redirect, req_valid, req_we, sb_flush;
  logic [AW-1:0] f_target, req_addr, f_pc, addr, mem_addr;
  logic [DW-1:0] req_wdata, f_instr, rsp_data, q, data, q_mem;
  logic f_valid, req_ready, rsp_valid, sb_empty, wr_en;

  logic [DW-1:0] mem [32];
  logic [DW-1:0] ref_mem [32];
  logic [AW-1:0] wr_log [$];
  int n_tests = 0;
  int n_fail = 0;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } st_t;

  always #5 clk = ~clk;
  assign q     = mem[addr];
  assign q_mem = mem[mem_addr];

  mem_requester #(.DATA_W(DW), .ADDR_W(AW), .SB_DEPTH(DEPTH), .RESET_PC(0)) dut (
    .Clock(clk), .Resetn(rstn), .f_stall(f_stall), .f_redirect(f_redirect),
    .f_target(f_target), .f_pc(f_pc), .f_instr(f_instr), .f_valid(f_valid),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .sb_flush(sb_flush),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .sb_empty(sb_empty),
    .addr(addr), .q(q), .mem_addr(mem_addr), .data(data), .wr_en(wr_en),
    .q_mem(q_mem)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return DW'(32'h50000 + i * 257);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending stores as a queue, shadow memory, fetch state.
  initial begin : model
    st_t mq [$];
    int m_pc, n;
    logic [DW-1:0] m_instr, m_rd, hd;
    bit m_valid, m_rv, m_flush, exp_rdy, ld, hit, port_ld, exp_wr;
    for (int i = 0; i < 32; i++) begin
      mem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    m_pc = 0; m_instr = '0; m_rd = '0;
    m_valid = 0; m_rv = 0; m_flush = 0;
    forever begin
      @(negedge clk);
      n = mq.size();
      exp_rdy = !m_flush && (req_we || (n < DEPTH && (FWD || n == 0)));
      ld = req_valid && !req_we && exp_rdy;
      hit = 1'b0;
      hd = '0;
      if (FWD) foreach (mq[i]) if (mq[i].a == req_addr) begin hit = 1'b1; hd = mq[i].d; end
      port_ld = ld && !hit;
      exp_wr = rstn && n > 0 && !port_ld;

      chk("f_pc", 32'(f_pc), 32'(m_pc));
      chk("f_instr", 32'(f_instr), 32'(m_instr));
      chk("f_valid", 32'(f_valid), 32'(m_valid));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
      chk("rsp_data", 32'(rsp_data), 32'(m_rd));
      chk("sb_empty", 32'(sb_empty), 32'(n == 0));
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("wr_en", 32'(wr_en), 32'(exp_wr));
      if (exp_wr) begin
        chk("drain_addr", 32'(mem_addr), 32'(mq[0].a));
        chk("drain_data", 32'(data), 32'(mq[0].d));
      end
      if (rstn && port_ld) chk("load_addr", 32'(mem_addr), 32'(req_addr));

      if (exp_wr) ref_mem[mq[0].a] = mq[0].d;
      if (!rstn) begin
        mq.delete();
        m_pc = 0; m_instr = '0; m_valid = 0; m_rv = 0; m_rd = '0; m_flush = 0;
      end else begin
        if (f_redirect || !f_stall) begin
          m_instr = ref_mem[m_pc];
          m_valid = !f_redirect;
          m_pc = f_redirect ? int'(f_target) : (m_pc + 1) % 32;
        end
        m_rv = ld;
        if (ld) m_rd = hit ? hd : ref_mem[req_addr];
        if (m_flush) m_flush = (n > 1);
        else m_flush = sb_flush && n > 0;
        if (exp_wr) void'(mq.pop_front());
        if (req_valid && req_we && exp_rdy) mq.push_back('{a: req_addr, d: req_wdata});
      end

      // Environment memory: write lands on this negedge.
      if (wr_en) begin
        wr_log.push_back(mem_addr);
        mem[mem_addr] = data;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) cyc();
  endtask

  // Present a request until accepted; k returns the number of not-ready cycles.
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output int k);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      n_tests++; n_fail++;
      $display("FAIL issue_timeout: addr %0h never accepted", a);
    end
    cyc();
    req_valid = 1'b0;
  endtask

  initial begin : stim
    int k;
    rstn = 0; f_stall = 0; f_redirect = 0; f_target = '0; sb_flush = 0;
    req_valid = 1; req_we = 1; req_addr = 5'h05; req_wdata = 20'h00001;

    // Reset held with a pending store request
    repeat (3) begin
      @(negedge clk);
      chk("rst_wr_en", 32'(wr_en), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    end
    cyc();
    rstn = 1; req_valid = 0; req_we = 0;
    @(negedge clk); chk("pc0", 32'(f_pc), 32'h0); chk("valid0", 32'(f_valid), 32'h0);
    cyc(); @(negedge clk);
    chk("pc1", 32'(f_pc), 32'h1); chk("instr0", 32'(f_instr), 32'h50000);
    cyc(); @(negedge clk);
    chk("pc2", 32'(f_pc), 32'h2); chk("instr1", 32'(f_instr), 32'h50101);
    cyc();

    // Store then immediate load of the same address
    issue(1, 5'h10, 20'h0ABCD, k);
    issue(0, 5'h10, '0, k);
    chk("ld_wait", 32'(k), FWD ? 32'd0 : 32'd1);
    @(negedge clk);
    chk("ld_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("ld_rsp_data", 32'(rsp_data), 32'h0ABCD);
    cyc(); idle(3);

    // Back-to-back stores, then a load; drains stay in FIFO order
    wr_log.delete();
    issue(1, 5'h01, 20'h11111, k); chk("st1_ready", 32'(k), 32'd0);
    issue(1, 5'h02, 20'h22222, k); chk("st2_ready", 32'(k), 32'd0);
    issue(1, 5'h03, 20'h33333, k); chk("st3_ready", 32'(k), 32'd0);
    issue(0, 5'h1F, '0, k);
    idle(3);
    chk("drain_cnt", 32'(wr_log.size()), 32'd3);
    if (wr_log.size() == 3) begin
      chk("drain0", 32'(wr_log[0]), 32'h01);
      chk("drain1", 32'(wr_log[1]), 32'h02);
      chk("drain2", 32'(wr_log[2]), 32'h03);
    end

    // Fetch: redirect under stall, then wrap from 0x1E
    f_stall = 1; f_redirect = 1; f_target = 5'h07;
    cyc(); f_redirect = 0;
    @(negedge clk); chk("redir_pc", 32'(f_pc), 32'h07); chk("redir_valid", 32'(f_valid), 32'h0);
    cyc(); f_stall = 0; f_redirect = 1; f_target = 5'h1E;
    cyc(); f_redirect = 0;
    @(negedge clk); chk("wrap_pc0", 32'(f_pc), 32'h1E);
    cyc(); @(negedge clk);
    chk("wrap_pc1", 32'(f_pc), 32'h1F); chk("wrap_instr1", 32'(f_instr), 32'h51E1E);
    chk("wrap_valid1", 32'(f_valid), 32'h1);
    cyc(); @(negedge clk);
    chk("wrap_pc2", 32'(f_pc), 32'h00); chk("wrap_instr2", 32'(f_instr), 32'h51F1F);
    cyc(); idle(2);

    // Flush raised alongside the second store
    wr_log.delete();
    issue(1, 5'h08, 20'h08080, k);
    sb_flush = 1;
    issue(1, 5'h09, 20'h09090, k);
    sb_flush = 0;
    @(negedge clk);
    chk("flush_ready", 32'(req_ready), 32'h0);
    chk("flush_wr", 32'(wr_en), 32'h1);
    chk("flush_addr", 32'(mem_addr), 32'h09);
    cyc(); @(negedge clk);
    chk("flush_done_ready", 32'(req_ready), 32'h1);
    chk("flush_done_empty", 32'(sb_empty), 32'h1);
    chk("flush_done_wr", 32'(wr_en), 32'h0);
    chk("flush_pulses", 32'(wr_log.size()), 32'd2);
    cyc(); idle(2);

    // Mixed stores and loads over a few addresses
    for (int i = 0; i < 6; i++) begin
      issue(1, AW'(5'h14 + i % 3), DW'(32'h30000 + i), k);
      issue(0, AW'(5'h14 + (i + 1) % 3), '0, k);
    end
    idle(3);

    // Reset during the first drain cycle discards buffered stores
    issue(1, 5'h0C, 20'h0CCCC, k);
    rstn = 0; req_valid = 1; req_we = 1; req_addr = 5'h0D; req_wdata = 20'h0DDDD;
    @(negedge clk); chk("rstmid_wr", 32'(wr_en), 32'h0);
    cyc(); rstn = 1; req_valid = 0;
    @(negedge clk); chk("rstmid_empty", 32'(sb_empty), 32'h1);
    cyc(); idle(3);

    chk("mem_0c", 32'(mem[5'h0C]), 32'h50C0C);
    chk("mem_0d", 32'(mem[5'h0D]), 32'h50D0D);
    chk("mem_10", 32'(mem[5'h10]), 32'h0ABCD);
    chk("mem_02", 32'(mem[5'h02]), 32'h22222);
    chk("mem_09", 32'(mem[5'h09]), 32'h09090);
    for (int i = 0; i < 32; i++) chk("mem_final", 32'(mem[i]), 32'(ref_mem[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
